// File: rtl/spi_sck_gen.sv
// SPI serial-clock generator: produces SCK for a fixed number of bits and
// emits sample/shift strobes aligned to the SCK edges for the active mode.
module spi_sck_gen #(
    parameter int DIV_W = 32,
    parameter int NB_W  = 6
) (
    input  logic             clk_cpu,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [DIV_W-1:0] spi_bitrate,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [NB_W-1:0]  nbits,
    output logic             SCK,
    output logic             busy,
    output logic             done,
    output logic             sample,
    output logic             shift
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [DIV_W-1:0] half_q;
    logic [DIV_W-1:0] div_cnt;
    logic [6:0]       edge_cnt;
    logic [6:0]       edge_total;
    logic             cpol_q;
    logic             cpha_q;

    logic             accept;
    logic             wrap;
    logic [6:0]       next_edge;
    logic             last_edge;
    logic             odd_edge;

    assign accept    = start && (nbits != '0) && (nbits <= NB_W'(32));
    assign wrap      = (div_cnt == half_q - DIV_W'(1));
    assign next_edge = edge_cnt + 7'd1;
    assign last_edge = (next_edge == edge_total);
    assign odd_edge  = next_edge[0];
    assign busy      = (state == RUN);

    // Every transfer is 2*nbits edges; the last edge is forced to the latched
    // idle level so SCK always ends where the mode says it should.
    always_ff @(posedge clk_cpu or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            half_q     <= '0;
            div_cnt    <= '0;
            edge_cnt   <= '0;
            edge_total <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            SCK        <= 1'b0;
            done       <= 1'b0;
            sample     <= 1'b0;
            shift      <= 1'b0;
        end else begin
            done   <= 1'b0;
            sample <= 1'b0;
            shift  <= 1'b0;
            if (!en) begin
                state    <= IDLE;
                div_cnt  <= '0;
                edge_cnt <= '0;
                SCK      <= cpol;
            end else begin
                case (state)
                    IDLE: begin
                        SCK      <= cpol;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        if (accept) begin
                            state      <= RUN;
                            half_q     <= (spi_bitrate == '0) ? DIV_W'(1) : spi_bitrate;
                            cpol_q     <= cpol;
                            cpha_q     <= cpha;
                            edge_total <= 7'(nbits) << 1;
                        end
                    end
                    RUN: begin
                        if (wrap) begin
                            div_cnt  <= '0;
                            edge_cnt <= next_edge;
                            SCK      <= last_edge ? cpol_q : ~SCK;
                            // cpha=0 samples on odd edges, cpha=1 on even edges
                            sample   <= odd_edge ^ cpha_q;
                            shift    <= ~(odd_edge ^ cpha_q);
                            if (last_edge) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_sck_gen.sv
// Scoreboard bench for spi_sck_gen: the driver predicts every SCK event from
// the transfer parameters, a monitor pops and compares as events appear.
module tb_spi_sck_gen;

    localparam int DIV_W = 32;
    localparam int NB_W  = 6;

    logic             clk_cpu = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             start = 1'b0;
    logic [DIV_W-1:0] spi_bitrate = 6;
    logic             cpol = 1'b0;
    logic             cpha = 1'b0;
    logic [NB_W-1:0]  nbits = 8;
    logic             SCK, busy, done, sample, shift;

    spi_sck_gen #(.DIV_W(DIV_W), .NB_W(NB_W)) dut (
        .clk_cpu(clk_cpu), .rst(rst), .en(en), .start(start),
        .spi_bitrate(spi_bitrate), .cpol(cpol), .cpha(cpha), .nbits(nbits),
        .SCK(SCK), .busy(busy), .done(done), .sample(sample), .shift(shift)
    );

    always #5 clk_cpu = ~clk_cpu;

    typedef struct {
        int cyc;
        bit sck;
        bit smp;
        bit shf;
        bit dn;
    } evt_t;

    evt_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   busy_lo = 0;
    int   busy_hi = 0;
    int   busy_count = 0;
    int   sample_count = 0;
    bit   prev_sck = 1'b0;
    bit   model_sck = 1'b0;

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic report_fail(string name, int act, int exp);
        checks++;
        $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk_cpu) cyc <= cyc + 1;

    // Monitor: any SCK change or strobe is an event and must match the queue head.
    always @(posedge clk_cpu) begin
        evt_t e;
        #1;
        check_output("busy", busy, (cyc >= busy_lo && cyc < busy_hi));
        if (busy) busy_count++;
        if (sample) sample_count++;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            report_fail("missed_evt", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (SCK !== prev_sck || sample || shift || done) begin
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                report_fail("unexpected_evt", cyc, (exp_q.size() == 0) ? -1 : exp_q[0].cyc);
            end else begin
                e = exp_q.pop_front();
                check_output("evt_sck", SCK, e.sck);
                check_output("evt_sample", sample, e.smp);
                check_output("evt_shift", shift, e.shf);
                check_output("evt_done", done, e.dn);
            end
        end
        prev_sck = SCK;
    end

    task automatic push_level(int c, bit lvl);
        if (lvl != model_sck) begin
            exp_q.push_back('{c, lvl, 1'b0, 1'b0, 1'b0});
            model_sck = lvl;
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic apply_stimulus(bit cp, bit ph, int br, int nb, output int acc);
        int h;
        bit smp;
        cpol        = cp;
        cpha        = ph;
        spi_bitrate = DIV_W'(br);
        nbits       = NB_W'(nb);
        start       = 1'b1;
        acc         = cyc + 1;
        push_level(acc, cp);
        if (en && nb >= 1 && nb <= 32) begin
            h = (br == 0) ? 1 : br;
            for (int k = 1; k <= 2 * nb; k++) begin
                smp = ph ? (k % 2 == 0) : (k % 2 == 1);
                exp_q.push_back('{acc + k * h, (k % 2 == 1) ? !cp : cp, smp, !smp, k == 2 * nb});
            end
            busy_lo = acc;
            busy_hi = acc + 2 * nb * h;
        end
        @(negedge clk_cpu);
        start = 1'b0;
    endtask

    task automatic wait_end(int max_cycles);
        int n = 0;
        while ((exp_q.size() > 0 || cyc < busy_hi) && n < max_cycles) begin
            @(negedge clk_cpu);
            n++;
        end
        if (n >= max_cycles) begin
            report_fail("timeout", n, max_cycles);
            exp_q.delete();
        end else begin
            check_output("idle_sck", SCK, model_sck);
        end
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int nb;
        #1;
        check_output("rst_sck", SCK, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_sample", sample, 0);
        check_output("rst_shift", shift, 0);
        repeat (3) @(negedge clk_cpu);
        rst = 1'b1;
        en  = 1'b1;
        @(negedge clk_cpu);

        $display("[TB] mode 0, bitrate 6, 8 bits");
        sample_count = 0;
        apply_stimulus(0, 0, 6, 8, acc);
        wait_end(1000);
        check_output("mode0_samples", sample_count, 8);

        $display("[TB] mode 3, bitrate 12, 4 bits");
        busy_count = 0;
        apply_stimulus(1, 1, 12, 4, acc);
        wait_end(1000);
        check_output("mode3_busy_cycles", busy_count, 96);

        $display("[TB] bitrate change mid-transfer, start while busy");
        apply_stimulus(0, 0, 6, 8, acc);
        repeat (10) @(negedge clk_cpu);
        spi_bitrate = 12;
        nbits       = 2;
        start       = 1'b1;
        @(negedge clk_cpu);
        start = 1'b0;
        wait_end(1000);
        apply_stimulus(0, 0, 12, 2, acc);
        wait_end(1000);

        $display("[TB] bitrate 0, 1 bit, back to back");
        apply_stimulus(0, 0, 0, 1, acc);
        wait_end(100);
        apply_stimulus(0, 1, 1, 3, acc);
        wait_end(100);

        $display("[TB] enable dropped after 3 edges");
        apply_stimulus(0, 0, 6, 8, acc);
        while (cyc < acc + 18) @(negedge clk_cpu);
        en = 1'b0;
        exp_q.delete();
        model_sck = 1'b1;
        push_level(acc + 19, 1'b0);
        busy_hi = acc + 19;
        @(negedge clk_cpu);
        en = 1'b1;
        wait_end(100);
        apply_stimulus(0, 0, 4, 3, acc);
        wait_end(1000);

        $display("[TB] reset mid-transfer");
        apply_stimulus(0, 0, 6, 8, acc);
        while (cyc < acc + 20) @(negedge clk_cpu);
        #2;
        rst = 1'b0;
        exp_q.delete();
        prev_sck  = 1'b0;
        model_sck = 1'b0;
        busy_hi   = 0;
        #1;
        check_output("abort_sck", SCK, 0);
        check_output("abort_busy", busy, 0);
        check_output("abort_done", done, 0);
        check_output("abort_sample", sample, 0);
        check_output("abort_shift", shift, 0);
        repeat (2) @(negedge clk_cpu);
        rst = 1'b1;
        @(negedge clk_cpu);
        apply_stimulus(0, 0, 3, 2, acc);
        wait_end(1000);

        $display("[TB] illegal bit counts");
        apply_stimulus(0, 0, 6, 0, acc);
        repeat (20) @(negedge clk_cpu);
        check_output("nbits0_busy", busy, 0);
        apply_stimulus(0, 0, 6, 33, acc);
        repeat (20) @(negedge clk_cpu);
        check_output("nbits33_busy", busy, 0);

        $display("[TB] randomized transfers");
        for (int i = 0; i < 14; i++) begin
            nb = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 40)
                                             : int'($urandom_range(1, 6));
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           int'($urandom_range(0, 5)), nb, acc);
            wait_end(1000);
            repeat ($urandom_range(0, 2)) @(negedge clk_cpu);
        end

        repeat (4) @(negedge clk_cpu);
        if (exp_q.size() != 0) report_fail("leftover_evts", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
